// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: MEM-stage port M, secondary port D,
// the shared memory port, and the link-bit/error status lines.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m_req;
   logic          m_we;
   logic          m_ll;
   logic          m_sc;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          stall;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;

   logic          mem_ce;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_rdy;

   logic          llbit;
   logic          bus_err;

   modport master (
      output m_req, m_we, m_ll, m_sc, m_addr, m_wdata,
      input  m_rdata, m_ack, stall,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ack,
      input  mem_ce, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_rdy,
      input  llbit, bus_err
   );

   modport slave (
      input  m_req, m_we, m_ll, m_sc, m_addr, m_wdata,
      output m_rdata, m_ack, stall,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ack,
      output mem_ce, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_rdy,
      output llbit, bus_err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for MEM stage (M) and secondary master (D), with LL/SC link.
// Define DMEM_TIMEOUT_EN to abort accesses after MAX_WAIT cycles with bus_err.
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 15
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC_M,
      S_ACC_D,
      S_DONE_M,
      S_DONE_D
   } state_e;

   state_e        state_q;
   logic          last_d_q;
   logic          mem_ce_q;
   logic          mem_we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          m_ack_q;
   logic          d_ack_q;
   logic [DW-1:0] m_rdata_q;
   logic [DW-1:0] d_rdata_q;
   logic          llbit_q;
   logic [AW-3:0] link_q;
   logic          ll_q;
   logic          sc_q;
   logic          grant_m_d;
   logic          link_hit_d;

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("dmem_arbiter: MAX_WAIT must be at least 1");
   end

   // Round-robin: M wins a tie unless it was the last one served.
   assign grant_m_d  = bus.m_req & (~bus.d_req | last_d_q);
   assign link_hit_d = mem_we_q & (addr_q[AW-1:2] == link_q);

`ifdef DMEM_TIMEOUT_EN
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] cnt_q;
   logic          bus_err_q;
   logic          expire_d;

   assign expire_d    = (cnt_q == CW'(MAX_WAIT - 1));
   assign bus.bus_err = bus_err_q;
`else
   assign bus.bus_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_d_q  <= 1'b1;
         mem_ce_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         m_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         m_rdata_q <= '0;
         d_rdata_q <= '0;
         llbit_q   <= 1'b0;
         link_q    <= '0;
         ll_q      <= 1'b0;
         sc_q      <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
`endif
      end else begin
         m_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         bus_err_q <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
`ifdef DMEM_TIMEOUT_EN
               cnt_q <= '0;
`endif
               if (grant_m_d) begin
                  last_d_q <= 1'b0;
                  ll_q     <= bus.m_ll;
                  sc_q     <= bus.m_sc;
                  // A failing SC never reaches memory.
                  if (bus.m_sc && !llbit_q) begin
                     state_q   <= S_DONE_M;
                     m_ack_q   <= 1'b1;
                     m_rdata_q <= '0;
                  end else begin
                     state_q   <= S_ACC_M;
                     mem_ce_q  <= 1'b1;
                     mem_we_q  <= bus.m_we;
                     addr_q    <= bus.m_addr;
                     wdata_q   <= bus.m_wdata;
                  end
               end else if (bus.d_req) begin
                  last_d_q <= 1'b1;
                  state_q  <= S_ACC_D;
                  mem_ce_q <= 1'b1;
                  mem_we_q <= bus.d_we;
                  addr_q   <= bus.d_addr;
                  wdata_q  <= bus.d_wdata;
               end
            end
            S_ACC_M: begin
               if (bus.mem_rdy) begin
                  state_q  <= S_DONE_M;
                  mem_ce_q <= 1'b0;
                  m_ack_q  <= 1'b1;
                  if (sc_q) begin
                     m_rdata_q <= DW'(1);
                     llbit_q   <= 1'b0;
                  end else begin
                     m_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
                  end
                  if (ll_q && !mem_we_q) begin
                     llbit_q <= 1'b1;
                     link_q  <= addr_q[AW-1:2];
                  end
`ifdef DMEM_TIMEOUT_EN
               end else if (expire_d) begin
                  state_q   <= S_DONE_M;
                  mem_ce_q  <= 1'b0;
                  m_ack_q   <= 1'b1;
                  m_rdata_q <= '0;
                  bus_err_q <= 1'b1;
                  if (sc_q) llbit_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
`endif
               end
            end
            S_ACC_D: begin
               if (bus.mem_rdy) begin
                  state_q   <= S_DONE_D;
                  mem_ce_q  <= 1'b0;
                  d_ack_q   <= 1'b1;
                  d_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
                  if (link_hit_d) llbit_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
               end else if (expire_d) begin
                  state_q   <= S_DONE_D;
                  mem_ce_q  <= 1'b0;
                  d_ack_q   <= 1'b1;
                  d_rdata_q <= '0;
                  bus_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
`endif
               end
            end
            S_DONE_M: state_q <= S_IDLE;
            S_DONE_D: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_ce    = mem_ce_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.m_ack     = m_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.m_rdata   = m_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.llbit     = llbit_q;
   assign bus.stall     = bus.m_req & ~m_ack_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (port M) and a secondary master such as a loader or debug/DMA (port D).
- Sequences each access as a ce/we/addr transaction, waiting on a memory ready handshake.
- Owns the LL/SC link bit and link address.
- Drives the pipeline stall while a MEM-stage access is outstanding.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 15, timeout limit in cycles, used only with DMEM_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_req  in  1  MEM-stage request; held until m_ack
- m_we  in  1  write (sw/sc)
- m_ll  in  1  load-linked
- m_sc  in  1  store-conditional (m_we also high)
- m_addr  in  AW  byte address
- m_wdata  in  DW  store data
- m_rdata  out  DW  load data / SC result
- m_ack  out  1  one-cycle completion pulse
- stall  out  1  pipeline stall
- d_req, d_we  in  1  secondary request / write
- d_addr  in  AW  byte address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data
- d_ack  out  1  one-cycle completion pulse
- mem_ce, mem_we  out  1  memory enable / write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_rdy  in  1  memory completion, valid the cycle data is ready
- llbit  out  1  current link bit
- bus_err  out  1  timeout pulse, aligned with ack

Behaviour:
- Reset (rst=1 at clk edge), all take effect next cycle, including mid-transaction:
  - state=IDLE; mem_ce=mem_we=0; m_ack=d_ack=0; bus_err=0
  - m_rdata=d_rdata=0; llbit=0; link_addr=0; last_grant=D, so M wins the first tie
- States: IDLE, ACC_M, ACC_D, DONE_M, DONE_D.
- IDLE arbitration:
  - only m_req -> ACC_M; only d_req -> ACC_D
  - both -> grant the port not equal to last_grant (round-robin)
  - last_grant updates on grant
- ACC_x:
  - mem_ce=1, mem_we/mem_addr/mem_wdata taken from the granted port's inputs, held stable
  - stays in ACC_x until mem_rdy=1
  - on the mem_rdy edge: capture mem_rdata into x_rdata (reads; 0 for writes), go to DONE_x
- DONE_x:
  - x_ack=1 for exactly one cycle; mem_ce=0; requests ignored this cycle
  - next state IDLE, so minimum gap between accesses is 1 idle cycle
  - requester deasserts req in the cycle after ack
- Latency: grant at T, mem_rdy at T+k (k>=0 cycles after entering ACC), ack at T+k+1.
- stall = m_req & ~m_ack (combinational); high during the whole M wait, including while D holds the bus.
- LL:
  - m_ll read completion sets llbit=1, link_addr=m_addr[AW-1:2]
  - a later LL overwrites the link
- SC, decided in IDLE when granting M with m_sc=1:
  - llbit=0: no memory access (mem_ce stays 0); go IDLE->DONE_M directly; m_rdata=0
  - llbit=1: normal write; on completion llbit=0, m_rdata=1
- Link break: any completed D write with d_addr[AW-1:2]==link_addr clears llbit in its DONE_D cycle. An M plain sw does not clear llbit.
- Accesses are serialized, so LL set, SC clear and D-break never coincide.
- Addresses are passed unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - wait counter clears on entering ACC_x and increments each ACC cycle without mem_rdy
  - when the counter reaches MAX_WAIT: go to DONE_x with x_rdata=0 and bus_err=1 in the ack cycle
  - SC that times out: llbit=0, m_rdata=0
  - LL that times out does not set llbit
- Without the macro: no counter; ACC waits indefinitely; bus_err tied 0.

Test Plan:
- Reset, then m_req lw addr 0x10, mem_rdy 2 cycles after grant, mem_rdata=0xDEADBEEF -> m_ack pulse at grant+3, m_rdata=0xDEADBEEF, stall high until the ack cycle.
- m_req and d_req asserted together twice in a row -> first grant M, second D, third M; mem_addr matches the winner; each ack exactly 1 cycle.
- ll 0x40, then sc 0x40 data 0x55 -> llbit 1 after ll; sc performs write of 0x55, m_rdata=1, llbit=0. A second sc with no memory access (mem_ce stays 0) -> m_rdata=0, m_ack one cycle after grant.
- ll 0x40, d write 0x42, then sc 0x40 -> llbit cleared at DONE_D, sc returns 0, no write issued. Repeat with d write 0x80 -> sc succeeds.
- rst asserted during ACC_M with mem_rdy low -> next cycle mem_ce=0, llbit=0, no ack; following m_req completes normally.
- With DMEM_TIMEOUT_EN, MAX_WAIT=4, mem_rdy never asserted -> ack after 4 ACC cycles, bus_err=1, m_rdata=0. Without the macro -> no ack after 100 cycles, bus_err=0.
